// File: rtl/led_breathe.sv
// -----------------------------------------------------------------------------
// led_breathe
//   Breathing / crossfade driver for the IceBreaker green and red LEDs.
//   Green fades in while red fades out, and then the reverse, following a
//   RISE -> HOLD_HI -> FALL -> HOLD_LO brightness envelope. Each LED is
//   driven by a PWM compare against a free-running counter.
//
//   Optional feature macro: LED_BREATHE_GAMMA_EN
//     defined   : duty = (LEVEL*LEVEL) >> PWM_BITS  (approximately gamma 2)
//     undefined : duty = LEVEL                      (linear)
//
// Ports
//   CLK     in   1         hardware clock (12 MHz)
//   RST_N   in   1         asynchronous, active-low reset
//   EN      in   1         1 = run; 0 = freeze all state and blank both LEDs
//   LEDG_N  out  1         green LED, active-low, registered
//   LEDR_N  out  1         red LED, active-low, registered
//   LEVEL   out  PWM_BITS  current envelope level (before gamma)
//   STATE   out  2         0=RISE 1=HOLD_HI 2=FALL 3=HOLD_LO
//   STEP    out  1         registered 1-cycle pulse on each brightness step
// -----------------------------------------------------------------------------
module led_breathe #(
    parameter int unsigned PWM_BITS    = 8,
    parameter int unsigned STEP_CYCLES = 23437,
    parameter int unsigned HOLD_STEPS  = 64
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                EN,
    output logic                LEDG_N,
    output logic                LEDR_N,
    output logic [PWM_BITS-1:0] LEVEL,
    output logic [1:0]          STATE,
    output logic                STEP
);

    localparam int unsigned SCW       = (STEP_CYCLES <= 2) ? 1 : $clog2(STEP_CYCLES);
    localparam int unsigned HW        = (HOLD_STEPS <= 2) ? 1 : $clog2(HOLD_STEPS);
    // A hold count of 0 is treated as 1 step.
    localparam int unsigned HOLD_LAST = (HOLD_STEPS <= 1) ? 0 : HOLD_STEPS - 1;
    localparam logic [PWM_BITS-1:0] MAX = '1;

    typedef enum logic [1:0] {
        RISE    = 2'd0,
        HOLD_HI = 2'd1,
        FALL    = 2'd2,
        HOLD_LO = 2'd3
    } state_t;

    state_t              state_q;
    logic [PWM_BITS-1:0] level_q;
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic [SCW-1:0]      step_cnt_q;
    logic [HW-1:0]       hold_cnt_q;
    logic                step_q;
    logic                led_g_q;
    logic                led_r_q;

    logic                step_d;
    logic [PWM_BITS-1:0] duty;

    // EN gates the step, so a step due on the cycle EN falls is not taken.
    assign step_d = EN && (step_cnt_q == SCW'(STEP_CYCLES - 1));

`ifdef LED_BREATHE_GAMMA_EN
    logic [2*PWM_BITS-1:0] level_sq;
    assign level_sq = {{PWM_BITS{1'b0}}, level_q} * {{PWM_BITS{1'b0}}, level_q};
    assign duty     = level_sq[2*PWM_BITS-1:PWM_BITS];
`else
    assign duty     = level_q;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= RISE;
            level_q    <= '0;
            pwm_cnt_q  <= '0;
            step_cnt_q <= '0;
            hold_cnt_q <= '0;
            step_q     <= 1'b0;
            led_g_q    <= 1'b1;
            led_r_q    <= 1'b1;
        end else begin
            step_q  <= step_d;
            // Complementary compares: exactly one LED lit while enabled.
            led_g_q <= ~(EN & (duty >  pwm_cnt_q));
            led_r_q <= ~(EN & (duty <= pwm_cnt_q));

            if (EN) begin
                pwm_cnt_q  <= pwm_cnt_q + 1'b1;
                step_cnt_q <= step_d ? '0 : step_cnt_q + 1'b1;
            end

            if (step_d) begin
                case (state_q)
                    RISE: begin
                        if (level_q == MAX) begin
                            state_q    <= HOLD_HI;
                            hold_cnt_q <= '0;
                        end else begin
                            level_q <= level_q + 1'b1;
                        end
                    end
                    HOLD_HI: begin
                        if (hold_cnt_q == HW'(HOLD_LAST)) begin
                            state_q <= FALL;
                        end else begin
                            hold_cnt_q <= hold_cnt_q + 1'b1;
                        end
                    end
                    FALL: begin
                        if (level_q == '0) begin
                            state_q    <= HOLD_LO;
                            hold_cnt_q <= '0;
                        end else begin
                            level_q <= level_q - 1'b1;
                        end
                    end
                    HOLD_LO: begin
                        if (hold_cnt_q == HW'(HOLD_LAST)) begin
                            state_q <= RISE;
                        end else begin
                            hold_cnt_q <= hold_cnt_q + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign LEDG_N = led_g_q;
    assign LEDR_N = led_r_q;
    assign LEVEL  = level_q;
    assign STATE  = state_q;
    assign STEP   = step_q;

endmodule

// File: tb/tb_led_breathe.sv
// -----------------------------------------------------------------------------
// tb_led_breathe
//   Directed bench for led_breathe with PWM_BITS=3, STEP_CYCLES=4,
//   HOLD_STEPS=2 (MAX=7, period 20 steps = 80 cycles).
// -----------------------------------------------------------------------------
module tb_led_breathe;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       ledg_n;
    logic       ledr_n;
    logic [2:0] level;
    logic [1:0] state;
    logic       step;

    int checks = 0;
    int errors = 0;

    led_breathe #(
        .PWM_BITS   (3),
        .STEP_CYCLES(4),
        .HOLD_STEPS (2)
    ) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .EN    (en),
        .LEDG_N(ledg_n),
        .LEDR_N(ledr_n),
        .LEVEL (level),
        .STATE (state),
        .STEP  (step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected LEVEL / STATE after s steps (s = 0..24), written out by hand.
    int lvl_tab [0:24] = '{0,1,2,3,4,5,6,7,7,7,7,6,5,4,3,2,1,0,0,0,0,1,2,3,4};
    int st_tab  [0:24] = '{0,0,0,0,0,0,0,0,1,1,2,2,2,2,2,2,2,2,3,3,0,0,0,0,0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int duty_of(input int lvl);
`ifdef LED_BREATHE_GAMMA_EN
        return (lvl * lvl) >> 3;
`else
        return lvl;
`endif
    endfunction

    initial begin
        int g_low_hi;
        int r_low_hi;
        int g_low_lo;
        int d;
        int p;
        rst_n = 1'b0;
        en    = 1'b0;
        g_low_hi = 0;
        r_low_hi = 0;
        g_low_lo = 0;

        // Reset state
        tick();
        tick();
        check("rst_ledg", ledg_n, 1);
        check("rst_ledr", ledr_n, 1);
        check("rst_level", level, 0);
        check("rst_state", state, 0);
        check("rst_step", step, 0);

        // Release and free run. Posedge k after release: step_cnt before edge
        // is (k-1)%4, pwm before edge is (k-1)%8, steps land on k = 4,8,...
        rst_n = 1'b1;
        en    = 1'b1;
        for (int k = 1; k <= 97; k++) begin
            tick();
            check("run_step", step, (k % 4 == 0) ? 1 : 0);
            check("run_level", level, lvl_tab[k / 4]);
            check("run_state", state, st_tab[k / 4]);
            d = duty_of(lvl_tab[(k - 1) / 4]);
            p = (k - 1) % 8;
            check("run_ledg", ledg_n, (d > p) ? 0 : 1);
            check("run_ledr", ledr_n, (d <= p) ? 0 : 1);
            check("run_not_both", (!ledg_n && !ledr_n) ? 1 : 0, 0);
            // LEVEL=7 drives the compare for edges 29..36 (one full PWM period)
            if (k >= 29 && k <= 36) begin
                if (!ledg_n) g_low_hi++;
                if (!ledr_n) r_low_hi++;
            end
            // LEVEL=0 drives the compare for edges 69..76
            if (k >= 69 && k <= 76 && !ledg_n) g_low_lo++;
        end
`ifdef LED_BREATHE_GAMMA_EN
        check("hi_green_count", g_low_hi, 6);
        check("hi_red_count", r_low_hi, 2);
`else
        check("hi_green_count", g_low_hi, 7);
        check("hi_red_count", r_low_hi, 1);
`endif
        check("lo_green_count", g_low_lo, 0);

        // Freeze at LEVEL=4 in RISE with step_cnt=1
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("frz_ledg", ledg_n, 1);
            check("frz_ledr", ledr_n, 1);
            check("frz_step", step, 0);
            check("frz_level", level, 4);
            check("frz_state", state, 0);
        end
        // Resume: only 3 enabled cycles remain to the next step
        en = 1'b1;
        tick();
        check("res_step1", step, 0);
        tick();
        check("res_step2", step, 0);
        tick();
        check("res_step3", step, 1);
        check("res_level", level, 5);

        // Bring step_cnt to 3, then drop EN on exactly that cycle
        tick();
        tick();
        tick();
        check("pre_drop_step", step, 0);
        check("pre_drop_level", level, 5);
        en = 1'b0;
        tick();
        check("drop_step", step, 0);
        check("drop_level", level, 5);
        check("drop_ledg", ledg_n, 1);
        tick();
        check("drop_level2", level, 5);
        en = 1'b1;
        tick();
        check("ret_step", step, 1);
        check("ret_level", level, 6);

        // Asynchronous reset mid-ramp, away from any clock edge
        #2;
        rst_n = 1'b0;
        #1;
        check("async_ledg", ledg_n, 1);
        check("async_ledr", ledr_n, 1);
        check("async_level", level, 0);
        check("async_state", state, 0);
        check("async_step", step, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("rel_ledr", ledr_n, 0);
        check("rel_ledg", ledg_n, 1);
        check("rel_level", level, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
